csr_trap_ctrl: RTL
==================

CSR_TRAP_CTRL -- requirements
Module: csr_trap_ctrl

Interface
REQ-001 SHALL have parameter EXT_INT_BIT, default 11: bit index of the machine external-interrupt enable in mie.
REQ-002 SHALL have port clk, input, 1: the single clock.
REQ-003 SHALL have port rst, input, 1: reset; synchronous, active-high.
REQ-004 SHALL have port int_req_i, input, 1: level external interrupt request.
REQ-005 SHALL have ports ex_ecall_i, ex_ebreak_i and ex_mret_i, each input, 1: decoded instruction in ex stage.
REQ-006 SHALL have port ex_pc_i, input, 32: pc of the ex-stage instruction.
REQ-007 SHALL have ports csr_mstatus_i, csr_mie_i, csr_mtvec_i and csr_mepc_i, each input, 32: current CSR contents.
REQ-008 SHALL have ports wb_csr_we_i (input, 1), wb_csr_waddr_i (input, 12) and wb_csr_wdata_i (input, 32): write port from wb_stage.
REQ-009 SHALL have ports csr_we_o (output, 1), csr_waddr_o (output, 12) and csr_wdata_o (output, 32): merged write port to the CSR file.
REQ-010 SHALL have port hold_o, output, 1: stalls the pipeline.
REQ-011 SHALL have port flush_o, output, 1: flushes if/id/ex.
REQ-012 SHALL have ports jump_o (output, 1) and jump_addr_o (output, 32): pc redirect.

Function
REQ-013 SHALL use states IDLE, W_MEPC, W_MSTATUS, W_MCAUSE, W_MRET and JUMP.
REQ-014 SHALL accept events in IDLE in this priority: ecall/ebreak, then mret, then interrupt. An interrupt is taken only when int_req_i=1, csr_mstatus_i[3]=1 and csr_mie_i[EXT_INT_BIT]=1.
REQ-015 SHALL, on accept, latch ex_pc_i into epc_q and set cause_q: ecall 32'd11, ebreak 32'd3, interrupt 32'h8000000B.
REQ-016 SHALL transition on accept: trap goes to W_MEPC; mret goes to W_MRET.
REQ-017 SHALL drive hold_o=1 combinationally in the accept cycle and in every non-IDLE state.
REQ-018 SHALL write in W_MEPC: addr 12'h341, data epc_q; then go to W_MSTATUS.
REQ-019 SHALL write in W_MSTATUS: addr 12'h300, data = csr_mstatus_i with bit7 (MPIE) = bit3, bit3 (MIE) = 0, bits12:11 (MPP) = 2'b11; then go to W_MCAUSE.
REQ-020 SHALL write in W_MCAUSE: addr 12'h342, data cause_q; latch target_q = {csr_mtvec_i[31:2], 2'b00} (direct mode only); then go to JUMP.
REQ-021 SHALL write in W_MRET: addr 12'h300, data = csr_mstatus_i with bit3 = bit7 and bit7 = 1; latch target_q = csr_mepc_i; then go to JUMP.
REQ-022 SHALL in JUMP assert jump_o=1, flush_o=1 and jump_addr_o=target_q for exactly one cycle, then return to IDLE.
REQ-023 SHALL arbitrate the write port with wb winning: when wb_csr_we_i=1, the wb write passes through unchanged and the FSM holds its current state for that cycle.
REQ-024 SHALL pass wb writes straight through in IDLE and JUMP.
REQ-025 SHALL NOT accept new events outside IDLE. An interrupt still pending on return to IDLE is re-evaluated there.
REQ-026 SHALL give trap latency: accept at T, then MEPC/MSTATUS/MCAUSE writes at T+1..T+3 and jump at T+4, plus one cycle per wb-conflict cycle. Mret: write at T+1, jump at T+2.
REQ-027 SHALL drive jump_addr_o=0 and csr_waddr_o/csr_wdata_o=0 when the corresponding strobe is low.

Reset
REQ-028 SHALL on rst=1 at a clk edge, including mid-sequence, go to IDLE and clear epc_q, cause_q and target_q. No partial write is completed.
REQ-029 SHALL hold all outputs at 0 while rst=1 (hold_o, flush_o, jump_o, csr_we_o = 0), with wb pass-through suppressed.

Structure
REQ-030 SHALL take CSR address constants (MSTATUS 300, MIE 304, MTVEC 305, MEPC 341, MCAUSE 342) and cause codes from the shared define.v; FSM state encodings stay local.
REQ-031 SHALL be a single module with no sub-module; the write-port mux is inline.

Verification
REQ-032 SHALL cover ecall: ecall at pc 0x100, mstatus=0x8, mtvec=0x205 -> writes 341←0x100, 300←0x1880, 342←0xB; jump_o at T+4 to 0x204; hold_o high T..T+4.
REQ-033 SHALL cover mret: mstatus=0x1880, mepc=0x104, mret -> 300←0x1888 at T+1; jump to 0x104 at T+2.
REQ-034 SHALL cover interrupt gating: int_req_i=1 with mstatus[3]=0 -> no action. Set mstatus=0x8 and mie=0x800 -> mcause written 0x8000000B.
REQ-035 SHALL cover a wb conflict: wb write to 0x340 during W_MEPC -> wb write appears on the port, the MEPC write slips one cycle, and the jump occurs at T+5.
REQ-036 SHALL cover simultaneous events: ecall and int_req_i in the same cycle -> cause 0xB taken. Interrupt held high -> re-taken once back in IDLE only if mstatus[3]=1.
REQ-037 SHALL cover reset mid-sequence: rst=1 in W_MSTATUS -> next cycle IDLE, all outputs 0, and no 12'h342 write ever issued.

Source files
------------

// File: rtl/csr_trap_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// csr_trap_ctrl_pkg
// Shared machine-mode CSR addresses, trap cause codes and mstatus rewrite
// helpers for the trap/return sequencer (csr_trap_ctrl).
// ---------------------------------------------------------------------------
package csr_trap_ctrl_pkg;

    // Machine-mode CSR addresses
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    // mcause values (bit 31 marks an interrupt)
    localparam logic [31:0] CAUSE_ECALL   = 32'd11;
    localparam logic [31:0] CAUSE_EBREAK  = 32'd3;
    localparam logic [31:0] CAUSE_EXT_INT = 32'h8000_000B;

    // mstatus field positions
    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    // Trap entry: save MIE into MPIE, disable interrupts, MPP = machine.
    function automatic logic [31:0] trap_mstatus(input logic [31:0] s);
        logic [31:0] r;
        r               = s;
        r[MSTATUS_MPIE] = s[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        r[12:11]        = 2'b11;
        return r;
    endfunction

    // Trap return: restore MIE from MPIE, set MPIE.
    function automatic logic [31:0] mret_mstatus(input logic [31:0] s);
        logic [31:0] r;
        r               = s;
        r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/csr_trap_ctrl.sv
// ---------------------------------------------------------------------------
// csr_trap_ctrl
// Sequences machine-mode trap entry (ecall / ebreak / external interrupt) and
// trap return (mret) as a series of CSR writes followed by a PC redirect.
// The wb-stage CSR write always wins the shared write port; the sequencer
// simply waits a cycle whenever it is pre-empted.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   int_req_i                level external interrupt request
//   ex_ecall_i/ebreak_i/mret_i  decoded ex-stage instruction
//   ex_pc_i                  pc of the ex-stage instruction
//   csr_mstatus/mie/mtvec/mepc_i  current CSR contents
//   wb_csr_we/waddr/wdata_i  CSR write from wb stage
//   csr_we/waddr/wdata_o     merged CSR write port
//   hold_o                   pipeline stall
//   flush_o                  flush if/id/ex
//   jump_o, jump_addr_o      pc redirect
// ---------------------------------------------------------------------------
module csr_trap_ctrl
    import csr_trap_ctrl_pkg::*;
#(
    parameter int EXT_INT_BIT = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        int_req_i,
    input  logic        ex_ecall_i,
    input  logic        ex_ebreak_i,
    input  logic        ex_mret_i,
    input  logic [31:0] ex_pc_i,
    input  logic [31:0] csr_mstatus_i,
    input  logic [31:0] csr_mie_i,
    input  logic [31:0] csr_mtvec_i,
    input  logic [31:0] csr_mepc_i,
    input  logic        wb_csr_we_i,
    input  logic [11:0] wb_csr_waddr_i,
    input  logic [31:0] wb_csr_wdata_i,
    output logic        csr_we_o,
    output logic [11:0] csr_waddr_o,
    output logic [31:0] csr_wdata_o,
    output logic        hold_o,
    output logic        flush_o,
    output logic        jump_o,
    output logic [31:0] jump_addr_o
);

    typedef enum logic [2:0] {
        IDLE,
        W_MEPC,
        W_MSTATUS,
        W_MCAUSE,
        W_MRET,
        JUMP
    } state_t;

    state_t      state_q;
    logic [31:0] epc_q;
    logic [31:0] cause_q;
    logic [31:0] target_q;

    logic        trap_ev;
    logic        int_ev;
    logic        accept;
    logic        fsm_we;
    logic [11:0] fsm_waddr;
    logic [31:0] fsm_wdata;

    // Only the MIE enable bit and the aligned mtvec base are consumed.
    logic        unused_bits;
    assign unused_bits = ^{csr_mie_i, csr_mtvec_i[1:0]};

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and infers a latch.
        fsm_we    = 1'b0;
        fsm_waddr = '0;
        fsm_wdata = '0;

        trap_ev = ex_ecall_i | ex_ebreak_i;
        int_ev  = int_req_i & csr_mstatus_i[MSTATUS_MIE] & csr_mie_i[EXT_INT_BIT];
        accept  = (state_q == IDLE) && (trap_ev || ex_mret_i || int_ev);

        case (state_q)
            W_MEPC: begin
                fsm_we    = 1'b1;
                fsm_waddr = CSR_MEPC;
                fsm_wdata = epc_q;
            end
            W_MSTATUS: begin
                fsm_we    = 1'b1;
                fsm_waddr = CSR_MSTATUS;
                fsm_wdata = trap_mstatus(csr_mstatus_i);
            end
            W_MCAUSE: begin
                fsm_we    = 1'b1;
                fsm_waddr = CSR_MCAUSE;
                fsm_wdata = cause_q;
            end
            W_MRET: begin
                fsm_we    = 1'b1;
                fsm_waddr = CSR_MSTATUS;
                fsm_wdata = mret_mstatus(csr_mstatus_i);
            end
            default: ;
        endcase

        // Outputs: everything forced low during reset; wb wins the port.
        csr_we_o    = 1'b0;
        csr_waddr_o = '0;
        csr_wdata_o = '0;
        hold_o      = 1'b0;
        flush_o     = 1'b0;
        jump_o      = 1'b0;
        jump_addr_o = '0;
        if (!rst) begin
            if (wb_csr_we_i) begin
                csr_we_o    = 1'b1;
                csr_waddr_o = wb_csr_waddr_i;
                csr_wdata_o = wb_csr_wdata_i;
            end else if (fsm_we) begin
                csr_we_o    = 1'b1;
                csr_waddr_o = fsm_waddr;
                csr_wdata_o = fsm_wdata;
            end
            hold_o = accept || (state_q != IDLE);
            if (state_q == JUMP) begin
                flush_o     = 1'b1;
                jump_o      = 1'b1;
                jump_addr_o = target_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            // NOTE: all state, including the latched epc/cause/target, is
            // cleared so an aborted sequence leaves nothing behind.
            state_q  <= IDLE;
            epc_q    <= '0;
            cause_q  <= '0;
            target_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        epc_q <= ex_pc_i;
                        if (trap_ev) begin
                            cause_q <= ex_ecall_i ? CAUSE_ECALL : CAUSE_EBREAK;
                            state_q <= W_MEPC;
                        end else if (ex_mret_i) begin
                            state_q <= W_MRET;
                        end else begin
                            cause_q <= CAUSE_EXT_INT;
                            state_q <= W_MEPC;
                        end
                    end
                end
                // Write states advance only when the port was actually ours.
                W_MEPC: if (!wb_csr_we_i) state_q <= W_MSTATUS;
                W_MSTATUS: if (!wb_csr_we_i) state_q <= W_MCAUSE;
                W_MCAUSE: begin
                    if (!wb_csr_we_i) begin
                        target_q <= {csr_mtvec_i[31:2], 2'b00};
                        state_q  <= JUMP;
                    end
                end
                W_MRET: begin
                    if (!wb_csr_we_i) begin
                        target_q <= csr_mepc_i;
                        state_q  <= JUMP;
                    end
                end
                JUMP: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
